wb_load_unit: RTL

Parametrised writeback-select and load-alignment unit for the miniLA core, sitting between the MEM stage and the register-file write port. It selects the register write data from the ALU, flag, immediate, PC-link and load sources. It also runs the bus read for loads through a small FSM with a req/ack handshake. Byte and halfword loads can be sign- or zero-extended, and misaligned loads can optionally be split into two bus beats.

---
 rtl/wd_pkg.sv | 50 +++++
 rtl/load_align.sv | 26 ++
 rtl/wb_load_unit.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/wd_pkg.sv
// Shared definitions for the writeback/load unit: select encodings, FSM states, load decode.
// REQ2 exists only when MISALIGN_EN is defined (two-beat misaligned loads).
package wd_pkg;

    localparam logic [3:0] WD_C     = 4'd0;
    localparam logic [3:0] WD_F     = 4'd1;
    localparam logic [3:0] WD_SEXT  = 4'd2;
    localparam logic [3:0] WD_RDOB  = 4'd3;
    localparam logic [3:0] WD_RDOH  = 4'd4;
    localparam logic [3:0] WD_RDO   = 4'd5;
    localparam logic [3:0] WD_PCB   = 4'd6;
    localparam logic [3:0] WD_RDOBU = 4'd7;
    localparam logic [3:0] WD_RDOHU = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
`ifdef MISALIGN_EN
        ST_REQ2,
`endif
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } size_t;

    typedef struct packed {
        logic  is_load;
        size_t ld_size;
        logic  is_signed;
    } load_kind_t;

    function automatic load_kind_t decode_load(input logic [3:0] sel);
        load_kind_t k;
        k = '{is_load: 1'b0, ld_size: SZ_W, is_signed: 1'b0};
        case (sel)
            WD_RDOB:  k = '{is_load: 1'b1, ld_size: SZ_B, is_signed: 1'b1};
            WD_RDOH:  k = '{is_load: 1'b1, ld_size: SZ_H, is_signed: 1'b1};
            WD_RDO:   k = '{is_load: 1'b1, ld_size: SZ_W, is_signed: 1'b0};
            WD_RDOBU: k = '{is_load: 1'b1, ld_size: SZ_B, is_signed: 1'b0};
            WD_RDOHU: k = '{is_load: 1'b1, ld_size: SZ_H, is_signed: 1'b0};
            default:  k = '{is_load: 1'b0, ld_size: SZ_W, is_signed: 1'b0};
        endcase
        return k;
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load aligner: shifts a two-word {beat1,beat0} window down by the byte
// offset, then keeps a byte, halfword or word and sign/zero-extends it.
module load_align
    import wd_pkg::*;
(
    input  logic [63:0] window,
    input  logic [1:0]  byte_off,
    input  size_t       ld_size,
    input  logic        is_signed,
    output logic [31:0] data
);

    logic [31:0] shifted;

    assign shifted = 32'(window >> {byte_off, 3'b000});

    always_comb begin
        data = shifted;
        case (ld_size)
            SZ_B:    data = {{24{is_signed & shifted[7]}}, shifted[7:0]};
            SZ_H:    data = {{16{is_signed & shifted[15]}}, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/wb_load_unit.sv
// Writeback-select and load-alignment unit: source mux, req/ack bus-read FSM, aligner.
// Define MISALIGN_EN to split misaligned halfword/word loads into two bus beats.
module wb_load_unit
    import wd_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        rf_wd_sel,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] alu_c,
    input  logic              alu_f,
    input  logic [DATA_W-1:0] sext_ext2,
    input  logic [DATA_W-1:0] npc_pcb,
    output logic              bus_req,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data
);

    state_t            state_reg, state_next;
    size_t             size_reg, size_next;
    logic              sgn_reg, sgn_next;
    logic [1:0]        off_reg, off_next;
    logic              bus_req_reg, bus_req_next;
    logic [ADDR_W-1:0] bus_addr_reg, bus_addr_next;
    logic              wb_valid_reg, wb_valid_next;
    logic [DATA_W-1:0] wb_data_reg, wb_data_next;
`ifdef MISALIGN_EN
    logic [DATA_W-1:0] beat0_reg, beat0_next;
    logic              two_beat;
`endif

    load_kind_t        kind_in;
    logic [1:0]        off_in;
    logic [DATA_W-1:0] direct_data;
    logic [63:0]       window;
    logic [31:0]       aligned;

    assign kind_in  = decode_load(rf_wd_sel);
    assign in_ready = (state_reg == ST_IDLE);

    // Single-beat builds drop the low address bits a halfword/word cannot straddle.
    always_comb begin
        off_in = addr[1:0];
`ifndef MISALIGN_EN
        if (kind_in.ld_size == SZ_H) off_in[0] = 1'b0;
        if (kind_in.ld_size == SZ_W) off_in    = 2'b00;
`endif
    end

    always_comb begin
        direct_data = '0;
        case (rf_wd_sel)
            WD_C:    direct_data = alu_c;
            WD_F:    direct_data = {{(DATA_W-1){1'b0}}, alu_f};
            WD_SEXT: direct_data = sext_ext2;
            WD_PCB:  direct_data = npc_pcb;
            default: direct_data = '0;
        endcase
    end

    // The final beat is aligned straight from the bus so wb_data is ready in DONE.
    always_comb begin
        window = {32'b0, bus_rdata};
`ifdef MISALIGN_EN
        if (state_reg == ST_REQ2) window = {bus_rdata, beat0_reg};
`endif
    end

`ifdef MISALIGN_EN
    assign two_beat = ((size_reg == SZ_H) && (off_reg == 2'd3)) ||
                      ((size_reg == SZ_W) && (off_reg != 2'd0));
`endif

    load_align u_align (
        .window    (window),
        .byte_off  (off_reg),
        .ld_size   (size_reg),
        .is_signed (sgn_reg),
        .data      (aligned)
    );

    always_comb begin
        state_next    = state_reg;
        size_next     = size_reg;
        sgn_next      = sgn_reg;
        off_next      = off_reg;
        bus_req_next  = bus_req_reg;
        bus_addr_next = bus_addr_reg;
        wb_valid_next = 1'b0;
        wb_data_next  = wb_data_reg;
`ifdef MISALIGN_EN
        beat0_next    = beat0_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    size_next = kind_in.ld_size;
                    sgn_next  = kind_in.is_signed;
                    off_next  = off_in;
                    if (kind_in.is_load) begin
                        bus_req_next  = 1'b1;
                        bus_addr_next = {addr[ADDR_W-1:2], 2'b00};
                        state_next    = ST_REQ;
                    end else begin
                        wb_data_next  = direct_data;
                        wb_valid_next = 1'b1;
                        state_next    = ST_DONE;
                    end
                end
            end
            ST_REQ: begin
                if (bus_ack) begin
`ifdef MISALIGN_EN
                    if (two_beat) begin
                        beat0_next    = bus_rdata;
                        bus_addr_next = bus_addr_reg + ADDR_W'(4);
                        state_next    = ST_REQ2;
                    end else
`endif
                    begin
                        bus_req_next  = 1'b0;
                        wb_data_next  = aligned;
                        wb_valid_next = 1'b1;
                        state_next    = ST_DONE;
                    end
                end
            end
`ifdef MISALIGN_EN
            ST_REQ2: begin
                if (bus_ack) begin
                    bus_req_next  = 1'b0;
                    wb_data_next  = aligned;
                    wb_valid_next = 1'b1;
                    state_next    = ST_DONE;
                end
            end
`endif
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_reg    <= ST_IDLE;
            size_reg     <= SZ_W;
            sgn_reg      <= 1'b0;
            off_reg      <= 2'b00;
            bus_req_reg  <= 1'b0;
            bus_addr_reg <= '0;
            wb_valid_reg <= 1'b0;
            wb_data_reg  <= '0;
`ifdef MISALIGN_EN
            beat0_reg    <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            size_reg     <= size_next;
            sgn_reg      <= sgn_next;
            off_reg      <= off_next;
            bus_req_reg  <= bus_req_next;
            bus_addr_reg <= bus_addr_next;
            wb_valid_reg <= wb_valid_next;
            wb_data_reg  <= wb_data_next;
`ifdef MISALIGN_EN
            beat0_reg    <= beat0_next;
`endif
        end
    end

    assign bus_req  = bus_req_reg;
    assign bus_addr = bus_addr_reg;
    assign wb_valid = wb_valid_reg;
    assign wb_data  = wb_data_reg;

endmodule
